// File: rtl/yv_pkg.sv
// yv_pkg: shared constants, state encoding and FIFO entry type for the Y/V row accumulator
package yv_pkg;
  localparam int YV_DATA_W = 16;
  localparam int YV_ACC_W = 40;
  localparam int YV_ROW_W = 11;
  localparam int YV_FIFO_DEPTH = 4;
  localparam logic [2:0] NEWROW_TAG = 3'b111;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} yv_state_e;
  typedef struct packed {
    logic [YV_ACC_W-1:0] sum;
    logic [YV_ROW_W-1:0] row;
  } yv_entry_t;
endpackage

// File: rtl/yv_sum_fifo.sv
// yv_sum_fifo: synchronous FIFO of completed row sums
// Ports: clock, reset (async active-low), push_i/data_i write side, pop_i/data_o read side
// (data_o is 0 while empty), count_o occupancy, full_o/empty_o status.
module yv_sum_fifo
  import yv_pkg::*;
#(
  parameter type T = yv_entry_t,
  parameter int DEPTH = YV_FIFO_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  T mem [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  always_ff @(posedge clock)
    if (push_i) mem[wr_q] <= data_i;
  assign count_o = count_q;
  assign full_o = count_q == CW'(DEPTH);
  assign empty_o = count_q == '0;
  // Head is forced to zero when empty so outputs read 0 out of reset.
  assign data_o = empty_o ? '0 : mem[rd_q];
  // Push with pop on a full FIFO is legal; a lone push into a full FIFO is not.
  assert property (@(posedge clock) disable iff (!reset) !(push_i && full_o && !pop_i));
endmodule

// File: rtl/yv_row_accumulator.sv
// yv_row_accumulator: two-lane Y*V product accumulation into per-row sums, pushed to an output FIFO
// Ports: clock, reset (async active-low); in_valid/in_ready beat handshake with lanes y0/v0/nr0 and
// y1/v1/nr1; flush ends a matrix; out_valid/out_ready/out_sum/out_row FIFO head; busy activity.
// Build option: YV_ACC_SAT_EN makes the accumulate saturate and adds the sticky sat_flag output.
module yv_row_accumulator
  import yv_pkg::*;
#(
  parameter int DATA_W = YV_DATA_W,
  parameter int ACC_W = YV_ACC_W,
  parameter int ROW_W = YV_ROW_W,
  parameter int FIFO_DEPTH = YV_FIFO_DEPTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] y0,
  input  logic signed [DATA_W-1:0] y1,
  input  logic signed [DATA_W-1:0] v0,
  input  logic signed [DATA_W-1:0] v1,
  input  logic                     nr0,
  input  logic                     nr1,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_sum,
  output logic [ROW_W-1:0]         out_row,
  output logic                     busy
`ifdef YV_ACC_SAT_EN
  ,
  output logic                     sat_flag
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [ROW_W-1:0] row;
  } entry_t;
  yv_state_e state_q, state_d;
  logic s1_v_q, nr0_q, nr1_q, open_q, open_d;
  logic signed [2*DATA_W-1:0] m0, m1;
  logic signed [ACC_W-1:0] p0_q, p1_q, acc_q, acc_d, addend, sum;
  logic [ROW_W-1:0] row_q, row_d;
  logic [CW-1:0] count;
  logic accept, full, empty, pop, push, lane_push, drain_ready, drain_done;
  entry_t push_e, head_e;
  assign m0 = y0 * v0;
  assign m1 = y1 * v1;
  assign accept = in_valid && in_ready;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      s1_v_q <= 1'b0;
      nr0_q <= 1'b0;
      nr1_q <= 1'b0;
      p0_q <= '0;
      p1_q <= '0;
    end else begin
      s1_v_q <= accept;
      if (accept) begin
        p0_q <= ACC_W'(m0);
        p1_q <= ACC_W'(m1);
        nr0_q <= nr0;
        nr1_q <= nr1;
      end
    end
  // Only one add is ever needed: a lane-1 marker drops the p1 term, a lane-0 marker bypasses the adder.
  assign addend = nr1_q ? p0_q : p0_q + p1_q;
`ifdef YV_ACC_SAT_EN
  logic signed [ACC_W:0] wide;
  logic clamp, sat_q;
  assign wide = {acc_q[ACC_W-1], acc_q} + {addend[ACC_W-1], addend};
  assign clamp = wide[ACC_W] ^ wide[ACC_W-1];
  assign sum = clamp ? {wide[ACC_W], {(ACC_W-1){~wide[ACC_W]}}} : wide[ACC_W-1:0];
  assign sat_flag = sat_q;
`else
  assign sum = acc_q + addend;
`endif
  // The drain push may have to wait for a FIFO slot; the lane rules never push while draining.
  assign drain_ready = state_q == DRAIN && !s1_v_q;
  assign drain_done = drain_ready && (!open_q || !full || pop);
  assign lane_push = s1_v_q && (nr0_q ? open_q : nr1_q);
  assign push = lane_push || (drain_done && open_q);
  assign push_e = '{sum: lane_push && !nr0_q ? sum : acc_q, row: row_q};
  assign acc_d = drain_done ? '0 : !s1_v_q ? acc_q : nr1_q ? '0 : nr0_q ? p1_q : sum;
  assign open_d = drain_done ? 1'b0 : s1_v_q ? !nr1_q : open_q;
  assign row_d = drain_done ? '0 : push ? row_q + ROW_W'(1) : row_q;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      acc_q <= '0;
      open_q <= 1'b0;
      row_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q <= acc_d;
      open_q <= open_d;
      row_q <= row_d;
    end
`ifdef YV_ACC_SAT_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) sat_q <= 1'b0;
    else sat_q <= !drain_done && (sat_q || (s1_v_q && !nr0_q && clamp));
`endif
  always_comb
    state_d = state_q == IDLE ? (accept ? RUN : IDLE) :
              state_q == RUN ? (flush ? DRAIN : RUN) :
              (drain_done ? IDLE : DRAIN);
  // A beat is taken only while the FIFO has room for it beyond the one already in flight.
  always_comb begin
    in_ready = state_q != DRAIN && (CW'(FIFO_DEPTH) - count) > CW'(s1_v_q);
    busy = state_q != IDLE || !empty || s1_v_q;
  end
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign out_sum = head_e.sum;
  assign out_row = head_e.row;
  yv_sum_fifo #(.T(entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock(clock),
    .reset(reset),
    .push_i(push),
    .data_i(push_e),
    .pop_i(pop),
    .data_o(head_e),
    .count_o(count),
    .full_o(full),
    .empty_o(empty)
  );
endmodule
